// File: rtl/debug_digit_driver.sv
// Drives a multiplexed 3-digit 7-segment display from a debug byte, in hex or
// unsigned decimal (sequential double-dabble), committing new digits only at frame boundaries.
module debug_digit_driver #(
  parameter int unsigned CLK_DIV        = 14,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value,
  input  logic       mode_dec,
  output logic [6:0] seg,
  output logic       dp,
  output logic [2:0] dig_en,
  output logic       busy
);

  localparam int unsigned NUM_DIG = 3;
  localparam int unsigned DIG_W   = 5;  // {blank, nibble}
  localparam int unsigned BCD_W   = 12;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_SHIFT   = 2'd2;
  localparam logic [1:0] ST_PEND    = 2'd3;

  localparam logic [DIG_W-1:0] DIG_BLANK = 5'b1_0000;
  localparam logic [DIG_W-1:0] DIG_ZERO  = 5'b0_0000;
  localparam logic [6:0]       SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic             DP_OFF    = SEG_ACTIVE_LOW;

  logic [CLK_DIV-1:0]              cnt_q, cnt_d;
  logic [1:0]                      idx_q, idx_d;
  logic [1:0]                      state_q, state_d;
  logic [7:0]                      last_val_q, last_val_d;
  logic                            last_dec_q, last_dec_d;
  logic [7:0]                      bin_q, bin_d;
  logic [BCD_W-1:0]                bcd_q, bcd_d;
  logic [2:0]                      shcnt_q, shcnt_d;
  logic [NUM_DIG-1:0][DIG_W-1:0]   pend_q, pend_d;
  logic                            pend_hex_q, pend_hex_d;
  logic [NUM_DIG-1:0][DIG_W-1:0]   shown_q, shown_d;
  logic                            shown_hex_q, shown_hex_d;
  logic [2:0]                      dig_en_q, dig_en_d;
  logic [6:0]                      seg_q, seg_d;
  logic                            dp_q, dp_d;
  logic                            busy_q, busy_d;

  logic                            tick_c;
  logic                            frame_end_c;
  logic [DIG_W-1:0]                cur_dig_c;
  logic [6:0]                      seg_raw_c;
  logic                            dp_raw_c;
  logic [BCD_W-1:0]                bcd_adj_c;
  logic [3:0]                      hun_c, ten_c, one_c;

  function automatic logic [6:0] seg_map(input logic [3:0] n);
    case (n)
      4'h0: seg_map = 7'h3F;
      4'h1: seg_map = 7'h06;
      4'h2: seg_map = 7'h5B;
      4'h3: seg_map = 7'h4F;
      4'h4: seg_map = 7'h66;
      4'h5: seg_map = 7'h6D;
      4'h6: seg_map = 7'h7D;
      4'h7: seg_map = 7'h07;
      4'h8: seg_map = 7'h7F;
      4'h9: seg_map = 7'h6F;
      4'hA: seg_map = 7'h77;
      4'hB: seg_map = 7'h7C;
      4'hC: seg_map = 7'h39;
      4'hD: seg_map = 7'h5E;
      4'hE: seg_map = 7'h79;
      default: seg_map = 7'h71;
    endcase
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    add3 = (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  assign tick_c      = &cnt_q;
  assign frame_end_c = tick_c && (idx_q == 2'd2);

  // Next-state: scan, output staging and conversion FSM
  always_comb begin
    cnt_d       = cnt_q + CLK_DIV'(1);
    idx_d       = idx_q;
    state_d     = state_q;
    last_val_d  = last_val_q;
    last_dec_d  = last_dec_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    shcnt_d     = shcnt_q;
    pend_d      = pend_q;
    pend_hex_d  = pend_hex_q;
    shown_d     = shown_q;
    shown_hex_d = shown_hex_q;
    dig_en_d    = dig_en_q;
    seg_d       = seg_q;
    dp_d        = dp_q;
    cur_dig_c   = shown_q[idx_q];
    seg_raw_c   = cur_dig_c[4] ? 7'h00 : seg_map(cur_dig_c[3:0]);
    dp_raw_c    = (idx_q == 2'd0) && shown_hex_q;
    bcd_adj_c   = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    hun_c       = '0;
    ten_c       = '0;
    one_c       = '0;

    // Segments are staged from the pre-commit digits so a frame is never torn
    if (tick_c) begin
      idx_d    = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      dig_en_d = 3'b001 << idx_q;
      seg_d    = SEG_ACTIVE_LOW ? ~seg_raw_c : seg_raw_c;
      dp_d     = SEG_ACTIVE_LOW ? ~dp_raw_c : dp_raw_c;
    end

    case (state_q)
      ST_IDLE: begin
        if ((value != last_val_q) || (mode_dec != last_dec_q)) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        last_val_d = value;
        last_dec_d = mode_dec;
        if (mode_dec) begin
          bin_d   = value;
          bcd_d   = '0;
          shcnt_d = '0;
          state_d = ST_SHIFT;
        end else begin
          pend_d[2]  = DIG_BLANK;
          pend_d[1]  = {1'b0, value[7:4]};
          pend_d[0]  = {1'b0, value[3:0]};
          pend_hex_d = 1'b1;
          state_d    = ST_PEND;
        end
      end
      ST_SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj_c[BCD_W-2:0], bin_q, 1'b0};
        shcnt_d        = shcnt_q + 3'd1;
        if (shcnt_q == 3'd7) begin
          hun_c      = bcd_d[11:8];
          ten_c      = bcd_d[7:4];
          one_c      = bcd_d[3:0];
          pend_d[2]  = {(hun_c == 4'd0), hun_c};
          pend_d[1]  = {(hun_c == 4'd0) && (ten_c == 4'd0), ten_c};
          pend_d[0]  = {1'b0, one_c};
          pend_hex_d = 1'b0;
          state_d    = ST_PEND;
        end
      end
      default: begin
        if (frame_end_c) begin
          shown_d     = pend_q;
          shown_hex_d = pend_hex_q;
          state_d     = ST_IDLE;
        end
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      state_q     <= ST_IDLE;
      last_val_q  <= '0;
      last_dec_q  <= 1'b0;
      bin_q       <= '0;
      bcd_q       <= '0;
      shcnt_q     <= '0;
      pend_q      <= {DIG_BLANK, DIG_ZERO, DIG_ZERO};
      pend_hex_q  <= 1'b1;
      shown_q     <= {DIG_BLANK, DIG_ZERO, DIG_ZERO};
      shown_hex_q <= 1'b1;
      dig_en_q    <= 3'b000;
      seg_q       <= SEG_OFF;
      dp_q        <= DP_OFF;
      busy_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      state_q     <= state_d;
      last_val_q  <= last_val_d;
      last_dec_q  <= last_dec_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      shcnt_q     <= shcnt_d;
      pend_q      <= pend_d;
      pend_hex_q  <= pend_hex_d;
      shown_q     <= shown_d;
      shown_hex_q <= shown_hex_d;
      dig_en_q    <= dig_en_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      busy_q      <= busy_d;
    end
  end

  assign seg    = seg_q;
  assign dp     = dp_q;
  assign dig_en = dig_en_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_debug_digit_driver.sv
// Self-checking bench for debug_digit_driver: random and directed stimulus against a
// job-level display model (arithmetic digit extraction, latency counts, frame-boundary commit).
module tb_debug_digit_driver;

  localparam int unsigned CLK_DIV = 4;
  localparam int          PERIOD  = 1 << CLK_DIV;
  localparam int          BLANK   = 16;
  localparam logic [6:0]  GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] value;
  logic       mode_dec;
  logic [6:0] seg;
  logic       dp;
  logic [2:0] dig_en;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int         m_cnt, m_idx;
  logic [2:0] m_dig;
  logic [6:0] m_seg;
  logic       m_dp, m_busy;
  int         m_shown [3];
  bit         m_shown_hex;
  bit         m_active;
  longint     m_edge, m_cap_edge, m_ready_edge;
  logic [7:0] m_last_val, m_job_val;
  logic       m_last_dec, m_job_dec;

  debug_digit_driver #(.CLK_DIV(CLK_DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .mode_dec (mode_dec),
    .seg      (seg),
    .dp       (dp),
    .dig_en   (dig_en),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input int d);
    if (d >= BLANK) return 7'h00;
    return GLYPH[d];
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_idx = 0;
    m_dig = 3'b000; m_seg = 7'h7F; m_dp = 1'b1; m_busy = 1'b0;
    m_shown[0] = 0; m_shown[1] = 0; m_shown[2] = BLANK; m_shown_hex = 1'b1;
    m_active = 1'b0; m_edge = 0; m_cap_edge = 0; m_ready_edge = 0;
    m_last_val = 8'd0; m_last_dec = 1'b0; m_job_val = 8'd0; m_job_dec = 1'b0;
  endtask

  task automatic model_commit();
    int v, h, t, o;
    v = int'(m_job_val);
    if (m_job_dec) begin
      h = v / 100; t = (v / 10) % 10; o = v % 10;
      m_shown[2] = (h == 0) ? BLANK : h;
      m_shown[1] = (h == 0 && t == 0) ? BLANK : t;
      m_shown[0] = o;
      m_shown_hex = 1'b0;
    end else begin
      m_shown[2] = BLANK; m_shown[1] = v / 16; m_shown[0] = v % 16;
      m_shown_hex = 1'b1;
    end
  endtask

  // One clock edge of the model: display scan, then the conversion job timeline
  task automatic model_edge();
    bit tick, frame_end;
    tick      = (m_cnt == PERIOD - 1);
    frame_end = tick && (m_idx == 2);
    if (tick) begin
      m_dig = 3'(1 << m_idx);
      m_seg = ~glyph(m_shown[m_idx]);
      m_dp  = !(m_idx == 0 && m_shown_hex);
    end
    if (!m_active) begin
      if (value !== m_last_val || mode_dec !== m_last_dec) begin
        m_active   = 1'b1;
        m_cap_edge = m_edge + 1;
      end
    end else if (m_edge == m_cap_edge) begin
      m_job_val = value; m_job_dec = mode_dec;
      m_last_val = value; m_last_dec = mode_dec;
      m_ready_edge = m_edge + (mode_dec ? 8 : 0);
    end else if (m_edge > m_ready_edge && frame_end) begin
      model_commit();
      m_active = 1'b0;
    end
    m_busy = m_active;
    m_cnt  = (m_cnt + 1) % PERIOD;
    if (tick) m_idx = (m_idx + 1) % 3;
    m_edge++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; value = 8'd0; mode_dec = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy, dp, dig_en, seg} !== {1'b0, 1'b1, 3'b000, 7'h7F}) begin
      $display("FAIL reset_hold got=%h exp=%h", {busy, dp, dig_en, seg}, {1'b0, 1'b1, 3'b000, 7'h7F});
      miscompares++;
    end
    @(negedge clk) reset = 1'b1;
    model_reset();
    for (int i = 0; i < PERIOD - 1; i++) step();
    vectors++;
    if (dig_en !== 3'b000) begin
      $display("FAIL reset_pre_tick got=%b exp=000", dig_en);
      miscompares++;
    end
    step();
    vectors++;
    if (dig_en !== 3'b001) begin
      $display("FAIL reset_first_tick got=%b exp=001", dig_en);
      miscompares++;
    end
    for (int i = 0; i < 4 * PERIOD; i++) begin
      step();
      vectors++;
      if ({busy, dp, dig_en, seg} !== {m_busy, m_dp, m_dig, m_seg}) begin
        $display("FAIL reset_scan cyc=%0d got=%h exp=%h", i, {busy, dp, dig_en, seg}, {m_busy, m_dp, m_dig, m_seg});
        miscompares++;
      end
    end
  endtask

  task automatic test_hex();
    value = 8'hA7; mode_dec = 1'b0;
    for (int i = 0; i < 8 * PERIOD; i++) begin
      step();
      vectors++;
      if ({busy, dp, dig_en, seg} !== {m_busy, m_dp, m_dig, m_seg}) begin
        $display("FAIL hex_a7 cyc=%0d got=%h exp=%h", i, {busy, dp, dig_en, seg}, {m_busy, m_dp, m_dig, m_seg});
        miscompares++;
      end
    end
  endtask

  task automatic test_decimal();
    logic [7:0] vals [2];
    vals[0] = 8'd255; vals[1] = 8'd7;
    for (int k = 0; k < 2; k++) begin
      value = vals[k]; mode_dec = 1'b1;
      for (int i = 0; i < 9 * PERIOD; i++) begin
        step();
        vectors++;
        if ({busy, dp, dig_en, seg} !== {m_busy, m_dp, m_dig, m_seg}) begin
          $display("FAIL dec_%0d cyc=%0d got=%h exp=%h", vals[k], i, {busy, dp, dig_en, seg}, {m_busy, m_dp, m_dig, m_seg});
          miscompares++;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    value = 8'd100; mode_dec = 1'b1;
    for (int i = 0; i < 14 * PERIOD; i++) begin
      step();
      if (i == 4) value = 8'd42;
      vectors++;
      if ({busy, dp, dig_en, seg} !== {m_busy, m_dp, m_dig, m_seg}) begin
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", i, {busy, dp, dig_en, seg}, {m_busy, m_dp, m_dig, m_seg});
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    value = 8'd200; mode_dec = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if ({busy, dp, dig_en, seg} !== {m_busy, m_dp, m_dig, m_seg}) begin
        $display("FAIL mid_shift_pre cyc=%0d got=%h exp=%h", i, {busy, dp, dig_en, seg}, {m_busy, m_dp, m_dig, m_seg});
        miscompares++;
      end
    end
    #1 reset = 1'b0;
    #1;
    vectors++;
    if ({busy, dp, dig_en, seg} !== {1'b0, 1'b1, 3'b000, 7'h7F}) begin
      $display("FAIL mid_shift_async got=%h exp=%h", {busy, dp, dig_en, seg}, {1'b0, 1'b1, 3'b000, 7'h7F});
      miscompares++;
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    model_reset();
    for (int i = 0; i < 9 * PERIOD; i++) begin
      step();
      vectors++;
      if ({busy, dp, dig_en, seg} !== {m_busy, m_dp, m_dig, m_seg}) begin
        $display("FAIL mid_shift_restart cyc=%0d got=%h exp=%h", i, {busy, dp, dig_en, seg}, {m_busy, m_dp, m_dig, m_seg});
        miscompares++;
      end
    end
  endtask

  task automatic test_mode_toggle();
    value = 8'h10; mode_dec = 1'b0;
    for (int i = 0; i < 18 * PERIOD; i++) begin
      step();
      if (i == 9 * PERIOD) mode_dec = 1'b1;
      vectors++;
      if ({busy, dp, dig_en, seg} !== {m_busy, m_dp, m_dig, m_seg}) begin
        $display("FAIL mode_toggle cyc=%0d got=%h exp=%h", i, {busy, dp, dig_en, seg}, {m_busy, m_dp, m_dig, m_seg});
        miscompares++;
      end
    end
  endtask

  task automatic test_random();
    int hold;
    for (int n = 0; n < 16; n++) begin
      value    = 8'($urandom);
      mode_dec = 1'($urandom);
      hold     = int'($urandom_range(5, 10 * PERIOD));
      for (int i = 0; i < hold; i++) begin
        step();
        vectors++;
        if ({busy, dp, dig_en, seg} !== {m_busy, m_dp, m_dig, m_seg}) begin
          $display("FAIL random n=%0d cyc=%0d val=%h dec=%b got=%h exp=%h", n, i, value, mode_dec,
                   {busy, dp, dig_en, seg}, {m_busy, m_dp, m_dig, m_seg});
          miscompares++;
        end
      end
    end
    value = 8'd0; mode_dec = 1'b0;
    for (int i = 0; i < 9 * PERIOD; i++) begin
      step();
      vectors++;
      if ({busy, dp, dig_en, seg} !== {m_busy, m_dp, m_dig, m_seg}) begin
        $display("FAIL random_settle cyc=%0d got=%h exp=%h", i, {busy, dp, dig_en, seg}, {m_busy, m_dp, m_dig, m_seg});
        miscompares++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_hex();
    test_decimal();
    test_back_to_back();
    test_reset_mid_shift();
    test_mode_toggle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/debug_digit_driver.md
Name: debug_digit_driver

Overview:
- Downstream stage of the memory-debug readout: consumes the 8-bit debug memory byte and drives a multiplexed 3-digit 7-segment display. This replaces the raw nibble-per-pin output.
- Supports two display modes: hex (two digits, 00-FF) and unsigned decimal (three digits, 0-255).
- Decimal conversion is a sequential shift-add-3 (double-dabble) engine.
- New digits are applied only at a scan-frame boundary, so the display never shows a torn value.

Parameters:
- CLK_DIV, 14: prescaler width. The scan advances one digit every 2^CLK_DIV clk cycles.
- SEG_ACTIVE_LOW, 1: when 1, seg and dp are inverted at the output (common-anode).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- value  input  8  byte to display.
- mode_dec  input  1  0 = hex, 1 = unsigned decimal.
- seg  output  7  segments {g,f,e,d,c,b,a}; polarity set by SEG_ACTIVE_LOW.
- dp  output  1  decimal point.
- dig_en  output  3  one-hot, active-high digit enable; bit0 = rightmost digit.
- busy  output  1  high while a conversion is in flight or a result is pending commit.

Behaviour:
- Reset (reset=0, asynchronous):
  - prescaler=0, digit index=0, FSM=IDLE.
  - Shown digits = {blank, 0, 0}, hex mode. Last-converted value/mode registers = 0/hex.
  - Outputs: dig_en=3'b000, seg=all off, dp=off, busy=0.
  - Reset asserted mid-conversion or mid-scan aborts immediately with no partial commit.
- Prescaler:
  - Free-running CLK_DIV-bit counter.
  - tick = 1 for one cycle when the counter is all-ones.
- Scan:
  - On tick, digit index goes 0 -> 1 -> 2 -> 0.
  - dig_en is registered and equals one-hot(index) starting from the first tick after reset. It stays 000 before that tick.
  - seg and dp are registered together with dig_en, so there is no cross-digit ghosting.
- Conversion FSM (IDLE, CAPTURE, SHIFT, PEND):
  - IDLE: if value != last_value or mode_dec != last_mode, go to CAPTURE. This also fires on the first cycle after reset whenever value != 0 or mode_dec = 1.
  - CAPTURE (1 cycle): latch value and mode into the work registers and update last_value/last_mode. In hex mode, go to PEND with digits {blank, value[7:4], value[3:0]}. In decimal mode, clear the 12-bit BCD accumulator and go to SHIFT with shift count 0.
  - SHIFT (exactly 8 cycles): each cycle, add 3 to any BCD nibble >= 5, then shift {bcd, bin} left by 1.
  - After the 8th shift, go to PEND with the hundreds/tens/ones digits.
  - PEND: wait for a tick that moves the index from 2 to 0 (frame boundary). On that cycle, copy the pending digits into the shown digits and return to IDLE.
- busy = (FSM != IDLE).
- Input changes during SHIFT or PEND are ignored. They are re-detected in IDLE after the commit, so the last stable value always wins.
- Latency from value change to pending:
  - Hex: 2 cycles (detect, capture).
  - Decimal: 10 cycles (detect, capture, 8 shifts).
  - Visible update happens at the next frame boundary, up to 3*2^CLK_DIV cycles later.
- Blanking:
  - Hex mode: digit 2 is blank.
  - Decimal mode: hundreds is blank if 0; tens is blank if hundreds=0 and tens=0.
  - Digit 0 is never blank.
  - A blank digit drives seg all off, but its dig_en still asserts.
- Segment map (active-high, gfedcba):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- dp: lit only on digit 0 while in hex mode (hex indicator).
- Width rules:
  - BCD nibbles are 4 bits; max decimal result is 2/5/5.
  - The prescaler wraps modulo 2^CLK_DIV; the digit index wraps 2 -> 0.

Test Plan:
- Reset then release, CLK_DIV=4, value=0, hex: dig_en=000 for the first 15 cycles, then 001,010,100 every 16 cycles. Digit 0 and digit 1 show seg=~3F (active-low), digit 2 all off, dp low-active on digit 0 only.
- value=8'hA7, hex: busy high for 2 cycles plus the wait to the frame boundary. The next frame shows digit 1=~77 and digit 0=~07.
- value=8'd255, mode_dec=1: exactly 8 SHIFT cycles, then shows 2,5,5 (~5B,~6D,~6D) with dp off. value=8'd7 decimal shows blank, blank, ~07.
- value changes 8'd100 -> 8'd42 during SHIFT: 100 is committed first, then 42 is reconverted and shown one frame later as blank,4,2.
- Assert reset during SHIFT: outputs go to the reset values immediately. After release, with value unchanged, conversion restarts from CAPTURE.
- Toggle mode_dec only, with value=8'h10 held: display goes from hex "10" with dp to decimal blank,1,6 without dp.
